// File: rtl/fan_result_collector.sv
// Captures one 32-lane FAN output vector and drains its result-valid lanes, lowest lane first, onto a valid/ready stream.
// Optional build macro FAN_COLLECT_SKIPZERO_EN: lanes whose sum is zero are dropped at capture.
module fan_result_collector #(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 32,
  parameter int DW_ROW  = 5,
  parameter int DW_CTRL = 4,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int DW_LANE = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_DATA-1:0]        out_data,
  output logic [DW_ROW-1:0]         out_row,
  output logic [DW_LANE-1:0]        out_lane,
  output logic                      out_last,
  output logic                      busy
);

  // Handshakes: a transfer happens on a clk edge where valid && ready; the
  // source holds its payload stable and never drops valid before that edge.
  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t               state_q;
  logic [NUM_IN-1:0]    pending_q;
  logic [NUM_IN-1:0]    pending_d;
  logic [DW_DATA-1:0]   data_q [NUM_IN];
  logic [DW_ROW-1:0]    row_q  [NUM_IN];

  logic [NUM_IN-1:0]    cap_mask;
  logic [DW_DATA-1:0]   lane_data [NUM_IN];
  logic [DW_ROW-1:0]    lane_row  [NUM_IN];
  logic [DW_CTRL-1:0]   lane_ctrl [NUM_IN];
  logic [DW_LANE-1:0]   sel_idx;
  logic [NUM_IN-1:0]    sel_onehot;
  logic                 one_left;
  logic                 unused_ctrl;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lane_data[g] = in[g*DW_LINE +: DW_DATA];
    assign lane_row[g]  = in[g*DW_LINE + DW_DATA +: DW_ROW];
    assign lane_ctrl[g] = in[g*DW_LINE + DW_DATA + DW_ROW +: DW_CTRL];
`ifdef FAN_COLLECT_SKIPZERO_EN
    assign cap_mask[g]  = lane_ctrl[g][0] && (lane_data[g] != '0);
`else
    assign cap_mask[g]  = lane_ctrl[g][0];
`endif
  end

  // Only ctrl[0] carries meaning; the upper control bits are deliberately dropped.
  always_comb begin
    unused_ctrl = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      unused_ctrl = unused_ctrl ^ (^lane_ctrl[i][DW_CTRL-1:1]);
    end
  end

  // Priority encoder: the lowest set pending bit wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = DW_LANE'(i);
    end
  end

  assign sel_onehot = NUM_IN'(1) << sel_idx;
  assign one_left   = (pending_q != '0) && ((pending_q & (pending_q - NUM_IN'(1))) == '0);
  assign pending_d  = pending_q & ~sel_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        data_q[i] <= '0;
        row_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_IN; i++) begin
              data_q[i] <= lane_data[i];
              row_q[i]  <= lane_row[i];
            end
            pending_q <= cap_mask;
            if (cap_mask != '0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            pending_q <= pending_d;
            if (one_left) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held low during reset so nothing is accepted until the first clean cycle.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && one_left;
  assign out_data  = data_q[sel_idx];
  assign out_row   = row_q[sel_idx];
  assign out_lane  = sel_idx;

endmodule

// File: tb/tb_fan_result_collector.sv
// Directed self-checking bench for fan_result_collector: capture, ordered drain, stalls, reset mid-drain, zero-skip.
module tb_fan_result_collector;

  localparam int NUM_IN  = 32;
  localparam int DW_DATA = 32;
  localparam int DW_ROW  = 5;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
  localparam int DW_LANE = 5;
  localparam int EW      = 1 + DW_LANE + DW_ROW + DW_DATA;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*DW_LINE-1:0] in_vec;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW_DATA-1:0]        out_data;
  logic [DW_ROW-1:0]         out_row;
  logic [DW_LANE-1:0]        out_lane;
  logic                      out_last;
  logic                      busy;

  logic [NUM_IN*DW_LINE-1:0] vec;
  logic [EW-1:0]             exp_q[$];
  int                        n_checks;
  int                        n_fail;
  int                        cyc;

  fan_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [DW_DATA-1:0] d, input logic [DW_ROW-1:0] r,
                          input logic [DW_CTRL-1:0] c);
    vec[i*DW_LINE +: DW_LINE] = {c, r, d};
  endtask

  task automatic push_exp(input int lane, input logic [DW_ROW-1:0] r, input logic [DW_DATA-1:0] d,
                          input logic last);
    exp_q.push_back({last, DW_LANE'(lane), r, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present vec for one cycle; returns in the cycle after the capture edge.
  task automatic capture();
    in_vec   = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Drain monitor: stalls out_ready over drain cycles [stall_lo, stall_hi].
  task automatic run_drain(input int max_cyc, input int stall_lo, input int stall_hi, input int exp_cyc);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin
      out_ready = !(c >= stall_lo && c <= stall_hi);
      got = {out_last, out_lane, out_row, out_data};
      check_val("drain_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        check_val("drain_in_ready", 64'(in_ready), 64'd0);
        check_val("drain_busy", 64'(busy), 64'd1);
        if (out_ready) begin
          exp = exp_q.pop_front();
          check_val("result", 64'(got), 64'(exp));
        end else begin
          check_val("hold", 64'(got), 64'(exp_q[0]));
        end
      end
      step();
      c++;
    end
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check_val("drain_cycles", 64'(c), 64'(exp_cyc));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic build_three();
    vec = '0;
    set_lane(3, 32'h11, 5'd1, 4'b0001);
    set_lane(4, 32'h99, 5'd4, 4'b1110);
    set_lane(8, 32'h22, 5'd2, 4'b0001);
    set_lane(31, 32'h33, 5'd7, 4'b0001);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    vec       = '0;

    // Reset state
    repeat (3) step();
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_out_last", 64'(out_last), 64'd0);
    check_val("rst_out_fields", 64'({out_lane, out_row, out_data}), 64'd0);
    rst = 1'b0;
    #1;
    check_val("rst_release_in_ready", 64'(in_ready), 64'd1);

    // Vector with no result-valid lanes (upper ctrl bits set) is consumed silently
    vec = '0;
    set_lane(2, 32'h55, 5'd3, 4'b1110);
    set_lane(9, 32'h66, 5'd4, 4'b0100);
    capture();
    for (int i = 0; i < 3; i++) begin
      check_idle("empty");
      step();
    end

    // Lanes 3, 8, 31, no stall
    build_three();
    capture();
    push_exp(3, 5'd1, 32'h11, 1'b0);
    push_exp(8, 5'd2, 32'h22, 1'b0);
    push_exp(31, 5'd7, 32'h33, 1'b1);
    run_drain(20, 1, 0, 3);
    check_idle("after_three");

    // Same vector, out_ready low on drain cycles 2-4
    build_three();
    capture();
    push_exp(3, 5'd1, 32'h11, 1'b0);
    push_exp(8, 5'd2, 32'h22, 1'b0);
    push_exp(31, 5'd7, 32'h33, 1'b1);
    run_drain(20, 1, 3, 6);
    check_idle("after_stall");

    // All 32 lanes, second vector held on in_valid throughout the drain
    vec = '0;
    for (int i = 0; i < NUM_IN; i++) set_lane(i, DW_DATA'(i + 1), DW_ROW'(i), 4'b0001);
    capture();
    vec = '0;
    set_lane(7, 32'hAB, 5'd3, 4'b0001);
    in_vec   = vec;
    in_valid = 1'b1;
    for (int i = 0; i < NUM_IN; i++) push_exp(i, DW_ROW'(i), DW_DATA'(i + 1), i == NUM_IN - 1);
    run_drain(60, 1, 0, 32);
    check_val("full_in_ready_after", 64'(in_ready), 64'd1);
    check_val("full_out_valid_after", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    push_exp(7, 5'd3, 32'hAB, 1'b1);
    run_drain(10, 1, 0, 1);
    check_idle("after_second");

    // Reset in the middle of a 32-lane drain, after lane 10
    vec = '0;
    for (int i = 0; i < NUM_IN; i++) set_lane(i, DW_DATA'(i + 1), DW_ROW'(i), 4'b0001);
    capture();
    for (int i = 0; i <= 10; i++) push_exp(i, DW_ROW'(i), DW_DATA'(i + 1), 1'b0);
    run_drain(30, 1, 0, 11);
    check_val("mid_lane11", 64'(out_lane), 64'd11);
    rst = 1'b1;
    step();
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check_val("mid_rst_fields", 64'({out_last, out_lane, out_row, out_data}), 64'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_idle("post_rst");
      step();
    end

    // Zero-sum lane handling
    vec = '0;
    set_lane(0, 32'h0, 5'd2, 4'b0001);
    set_lane(5, 32'h7, 5'd6, 4'b0001);
    capture();
`ifdef FAN_COLLECT_SKIPZERO_EN
    push_exp(5, 5'd6, 32'h7, 1'b1);
    run_drain(10, 1, 0, 1);
`else
    push_exp(0, 5'd2, 32'h0, 1'b0);
    push_exp(5, 5'd6, 32'h7, 1'b1);
    run_drain(10, 1, 0, 2);
`endif
    check_idle("after_zero");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard
  initial begin
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    $display("FAIL global_timeout got=%0d exp=<5000", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fan_result_collector.md
Name: fan_result_collector

Overview:
- Sits directly downstream of the 32-lane FAN reduction network in the sparse tensor core.
- Captures one 32-lane FAN output vector and identifies the lanes that hold final reduced row sums (result-valid flag set).
- Serialises those results, one per cycle, onto a valid/ready stream of (row, sum, lane) for the row write-back/accumulator stage.
- Applies backpressure to the FAN pipeline while draining.

Parameters:
- NUM_IN, 32, lane count (fixed 32).
- DW_DATA, 32, sum width.
- DW_ROW, 5, row-ID width.
- DW_CTRL, 4, per-lane control width.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, lane width.
- DW_LANE, 5, lane-index width (log2 NUM_IN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  FAN output vector valid.
- in_ready  out  1  collector can capture a vector.
- in  in  NUM_IN*DW_LINE  FAN output lanes.
  - Lane i = in[i*DW_LINE +: DW_LINE].
  - Lane layout: data [DW_DATA-1:0], row [DW_DATA+DW_ROW-1:DW_DATA], ctrl in the top DW_CTRL bits.
  - ctrl[0] = result-valid.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  DW_DATA  reduced sum.
- out_row  out  DW_ROW  row ID of sum.
- out_lane  out  DW_LANE  source lane index.
- out_last  out  1  final result of the current captured vector.
- busy  out  1  high in DRAIN.

Behaviour:
- Storage:
  - Capture buffer: NUM_IN lanes (data and row only).
  - pending mask: NUM_IN bits.
  - state: IDLE or DRAIN.
- Reset (rst=1 at a clk edge):
  - state=IDLE, pending=0, buffer cleared.
  - out_valid=0, out_last=0, busy=0, out_data/out_row/out_lane=0.
  - in_ready=0 while rst is high; 1 in the first cycle after rst deasserts.
  - rst mid-drain discards all pending results; no further outputs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch all lanes; pending[i] = lane i ctrl[0].
  - pending!=0 -> DRAIN next cycle. pending==0 -> stay IDLE; the vector is consumed silently and in_ready stays 1.
- DRAIN:
  - in_ready=0, busy=1, out_valid=1.
  - Selected lane = lowest-index set bit of pending.
  - out_data/out_row/out_lane come from the selected lane.
  - out_last = 1 when exactly one pending bit remains.
  - On out_valid&&out_ready: clear the selected bit. If out_last was set, go to IDLE (in_ready=1 the next cycle). Otherwise the next lowest bit is presented the next cycle.
  - out_ready=0: all out_* hold stable. out_valid is never deasserted without a handshake.
- Latency and throughput:
  - Capture at edge N -> first result valid in cycle N+1.
  - k results take k cycles with out_ready held high.
  - A vector with k results blocks the next capture for k cycles (no capture/drain overlap).
- Ordering: ascending lane index within a vector; vectors are emitted in capture order.
- ctrl bits [DW_CTRL-1:1] are ignored. Data passes through unmodified; no arithmetic.
- Output mux: registered pending mask plus combinational priority encoder; no combinational path from in to out_*.

Optional Feature:
- Macro: FAN_COLLECT_SKIPZERO_EN.
- Defined: at capture, pending[i] = ctrl[0] && (data != 0). Zero sums are never emitted, and an all-zero vector is consumed without entering DRAIN.
- Undefined: pending[i] = ctrl[0] only; zero sums are emitted normally.

Test Plan:
- Reset, then vector with no ctrl[0] bits, in_valid=1 for 1 cycle -> in_ready stays 1, out_valid never asserts, busy=0.
- Lanes 3, 8, 31 valid with data 0x11/0x22/0x33, rows 1/2/7, out_ready=1 -> out_valid for 3 consecutive cycles starting 1 cycle after capture.
  - Outputs in order (lane 3, row 1, 0x11), (8, 2, 0x22), (31, 7, 0x33).
  - out_last only on the third; in_ready=1 the cycle after.
- Same vector with out_ready low for cycles 2-4 of the drain -> the lane 8 result is held stable with out_valid=1, then resumes. Total of 3 handshakes, no duplicates.
- All 32 lanes valid, data = lane index+1 -> 32 consecutive results, lanes 0..31, out_last on lane 31. A second vector with in_valid held is captured only after that.
- rst asserted in the middle of the 32-lane drain (after lane 10) -> next cycle out_valid=0, pending cleared, in_ready=1 after rst drops, no further results.
- FAN_COLLECT_SKIPZERO_EN defined; lanes 0, 5 valid with data 0, 0x7 -> only (lane 5, 0x7) emitted with out_last=1. Macro undefined -> both emitted.
